// File: rtl/axi_rt_budget_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rt_budget_bank_if
// Description : Configuration, admission and status bundle of the RT budget bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rt_budget_bank_if #(
    parameter int NumChannels = 4,
    parameter int NumRegions  = 2,
    parameter int BudgetWidth = 32,
    parameter int PeriodWidth = 32,
    parameter int LenWidth    = 8,
    parameter int StallWidth  = 16,
    parameter int RegW        = (NumRegions > 1) ? $clog2(NumRegions) : 1
);
    logic [NumChannels-1:0]                             enable_i;
    logic [NumChannels-1:0]                             carry_i;
    logic [NumChannels*NumRegions-1:0][BudgetWidth-1:0] budget_i;
    logic [NumChannels*NumRegions-1:0][PeriodWidth-1:0] period_i;
    logic [NumChannels-1:0]                             consume_valid_i;
    logic [NumChannels-1:0][RegW-1:0]                   consume_region_i;
    logic [NumChannels-1:0][LenWidth-1:0]               consume_len_i;
    logic [NumChannels-1:0]                             consume_ready_o;
    logic [NumChannels*NumRegions-1:0][BudgetWidth-1:0] budget_left_o;
    logic [NumChannels*NumRegions-1:0][PeriodWidth-1:0] period_left_o;
    logic [NumChannels*NumRegions-1:0]                  exhausted_o;
    logic [NumChannels-1:0][StallWidth-1:0]             stall_cnt_o;

    modport master (
        output enable_i, carry_i, budget_i, period_i,
        output consume_valid_i, consume_region_i, consume_len_i,
        input  consume_ready_o, budget_left_o, period_left_o, exhausted_o, stall_cnt_o
    );

    modport slave (
        input  enable_i, carry_i, budget_i, period_i,
        input  consume_valid_i, consume_region_i, consume_len_i,
        output consume_ready_o, budget_left_o, period_left_o, exhausted_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/axi_rt_budget_bank.sv
`default_nettype none
// ============================================================================
// Module      : axi_rt_budget_bank
// Description : Per (channel, region) budget/period token counters with
//               admission, replenish, exhaustion flag and stall monitoring.
//               Define AXI_RT_BUDGET_CARRY_EN to build carry-over replenish.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rt_budget_bank #(
    parameter int NumChannels = 4,
    parameter int NumRegions  = 2,
    parameter int BudgetWidth = 32,
    parameter int PeriodWidth = 32,
    parameter int LenWidth    = 8,
    parameter int StallWidth  = 16,
    parameter int RegW        = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    axi_rt_budget_bank_if.slave  bus
);
    localparam int c_NE = NumChannels * NumRegions;
    localparam int c_CW = (BudgetWidth > LenWidth + 1) ? BudgetWidth : LenWidth + 1;

    logic [BudgetWidth-1:0] r_left        [c_NE];
    logic [PeriodWidth-1:0] r_period_left [c_NE];
    logic                   r_exhausted   [c_NE];
    logic [StallWidth-1:0]  r_stall       [NumChannels];

    logic [BudgetWidth-1:0] w_next_left   [c_NE];
    logic                   w_tick        [c_NE];
    logic                   w_ready       [NumChannels];

`ifndef AXI_RT_BUDGET_CARRY_EN
    logic w_unused_carry;
    assign w_unused_carry = ^bus.carry_i;
`endif

    for (genvar ch = 0; ch < NumChannels; ch++) begin : g_ch
        logic [c_CW-1:0]        w_beats;
        logic [BudgetWidth-1:0] w_sel_left;
        logic                   w_region_ok;
        logic                   w_fire;

        assign w_beats = c_CW'(bus.consume_len_i[ch]) + c_CW'(1);

        // An out-of-range region matches no entry and therefore never admits.
        always_comb begin
            w_sel_left  = '0;
            w_region_ok = 1'b0;
            for (int i = 0; i < NumRegions; i++) begin
                if (bus.consume_region_i[ch] == RegW'(i)) begin
                    w_sel_left  = r_left[ch*NumRegions + i];
                    w_region_ok = 1'b1;
                end
            end
        end

        assign w_ready[ch] = bus.enable_i[ch] && w_region_ok && (c_CW'(w_sel_left) >= w_beats);
        assign w_fire      = bus.consume_valid_i[ch] && w_ready[ch];

        for (genvar r = 0; r < NumRegions; r++) begin : g_rg
            localparam int c_E = ch*NumRegions + r;

            logic [BudgetWidth-1:0] w_repl;
            logic [c_CW-1:0]        w_repl_sub;
            logic [c_CW-1:0]        w_left_sub;
            logic                   w_hit;

            assign w_tick[c_E] = (r_period_left[c_E] <= PeriodWidth'(1));
            assign w_hit       = w_fire && (bus.consume_region_i[ch] == RegW'(r));

`ifdef AXI_RT_BUDGET_CARRY_EN
            logic [BudgetWidth:0] w_sum;
            logic [BudgetWidth:0] w_cap;
            logic [BudgetWidth:0] w_min;

            assign w_sum  = {1'b0, r_left[c_E]} + {1'b0, bus.budget_i[c_E]};
            assign w_cap  = {bus.budget_i[c_E], 1'b0};
            assign w_min  = (w_sum < w_cap) ? w_sum : w_cap;
            assign w_repl = !bus.carry_i[ch]   ? bus.budget_i[c_E] :
                            w_min[BudgetWidth] ? '1 : w_min[BudgetWidth-1:0];
`else
            assign w_repl = bus.budget_i[c_E];
`endif

            assign w_repl_sub = (c_CW'(w_repl) >= w_beats) ? (c_CW'(w_repl) - w_beats) : '0;
            // Admission guarantees left >= beats, so this never wraps.
            assign w_left_sub = c_CW'(r_left[c_E]) - w_beats;

            assign w_next_left[c_E] = w_tick[c_E]
                                    ? (w_hit ? BudgetWidth'(w_repl_sub) : w_repl)
                                    : (w_hit ? BudgetWidth'(w_left_sub) : r_left[c_E]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int ch = 0; ch < NumChannels; ch++) begin
            for (int r = 0; r < NumRegions; r++) begin
                if (!rst_ni) begin
                    r_left[ch*NumRegions + r]        <= '0;
                    r_period_left[ch*NumRegions + r] <= '0;
                    r_exhausted[ch*NumRegions + r]   <= 1'b0;
                end else if (!bus.enable_i[ch]) begin
                    r_left[ch*NumRegions + r]        <= bus.budget_i[ch*NumRegions + r];
                    r_period_left[ch*NumRegions + r] <= bus.period_i[ch*NumRegions + r];
                    r_exhausted[ch*NumRegions + r]   <= 1'b0;
                end else begin
                    r_left[ch*NumRegions + r] <= w_next_left[ch*NumRegions + r];
                    r_period_left[ch*NumRegions + r] <= w_tick[ch*NumRegions + r]
                        ? bus.period_i[ch*NumRegions + r]
                        : r_period_left[ch*NumRegions + r] - PeriodWidth'(1);
                    if (w_next_left[ch*NumRegions + r] == '0) begin
                        r_exhausted[ch*NumRegions + r] <= 1'b1;
                    end else if (w_tick[ch*NumRegions + r]) begin
                        r_exhausted[ch*NumRegions + r] <= 1'b0;
                    end
                end
            end

            if (!rst_ni || !bus.enable_i[ch]) begin
                r_stall[ch] <= '0;
            end else if (bus.consume_valid_i[ch] && !w_ready[ch] && (r_stall[ch] != '1)) begin
                r_stall[ch] <= r_stall[ch] + StallWidth'(1);
            end
        end
    end

    always_comb begin
        bus.consume_ready_o = '0;
        bus.budget_left_o   = '0;
        bus.period_left_o   = '0;
        bus.exhausted_o     = '0;
        bus.stall_cnt_o     = '0;
        for (int e = 0; e < c_NE; e++) begin
            bus.budget_left_o[e] = r_left[e];
            bus.period_left_o[e] = r_period_left[e];
            bus.exhausted_o[e]   = r_exhausted[e];
        end
        for (int ch = 0; ch < NumChannels; ch++) begin
            bus.consume_ready_o[ch] = w_ready[ch];
            bus.stall_cnt_o[ch]     = r_stall[ch];
        end
    end
endmodule
`default_nettype wire

// File: doc/axi_rt_budget_bank.md
# axi_rt_budget_bank

Parametrised budget/period accounting bank for the AXI real-time units: one independent token counter per (channel, address region) pair. Each channel admits transactions only while its region has budget left, and budgets are replenished every period. The bank generalises the fixed per-manager read/write budget logic to an arbitrary channel count and adds carry-over (token-bucket) replenishment and stall-cycle monitoring. It sits between the register file and the fragmenting/throttling datapath of each RT unit.

## Interface
- `NumChannels`, 4, independent channels (e.g. manager × {read, write}).
- `NumRegions`, 2, address regions per channel; region index width `RegW = max(1, $clog2(NumRegions))`.
- `BudgetWidth`, 32, width of budget counters, in beats.
- `PeriodWidth`, 32, width of period counters, in cycles.
- `LenWidth`, 8, width of AXI len; beats charged = len + 1.
- `StallWidth`, 16, width of the saturating stall counters.
- Array order for all `[NumChannels*NumRegions]` vectors: entry index = ch*NumRegions + r.
- `clk_i`, in, 1: clock; the block has exactly one clock.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `enable_i`, in, NumChannels: per-channel accounting enable.
- `carry_i`, in, NumChannels: per-channel mode. 0 = reset-to-budget, 1 = carry-over.
- `budget_i`, in, [NumChannels*NumRegions] × BudgetWidth: budget per period.
- `period_i`, in, [NumChannels*NumRegions] × PeriodWidth: period length in cycles.
- `consume_valid_i`, in, NumChannels: a transaction is requesting admission.
- `consume_region_i`, in, [NumChannels] × RegW: region targeted by the transaction.
- `consume_len_i`, in, [NumChannels] × LenWidth: AXI len of the transaction.
- `consume_ready_o`, out, NumChannels: admission grant.
- `budget_left_o`, out, [NumChannels*NumRegions] × BudgetWidth: remaining budget.
- `period_left_o`, out, [NumChannels*NumRegions] × PeriodWidth: remaining cycles in the current period.
- `exhausted_o`, out, [NumChannels*NumRegions]: budget for the entry reached 0 in the current period.
- `stall_cnt_o`, out, [NumChannels] × StallWidth: count of cycles with valid && !ready.

## Operation
- Reset values: `budget_left_o`, `period_left_o`, `exhausted_o` and `stall_cnt_o` are all 0. Therefore `consume_ready_o` is 0.
- Channel disabled (`enable_i`=0), every cycle, for all regions of the channel:
  - left ← `budget_i`; period_left ← `period_i`; exhausted ← 0; stall_cnt ← 0.
- Channel enabled: each region runs independently.
  - Period tick: if period_left ≤ 1, this is a replenish cycle and period_left ← `period_i`. Otherwise period_left ← period_left − 1. A `period_i` of 0 behaves as 1, i.e. replenish every cycle.
  - Replenish value R:
    - carry = 0: R = `budget_i`.
    - carry = 1: R = min(left + `budget_i`, 2·`budget_i`, 2^BudgetWidth − 1). The addition is done at BudgetWidth+1 bits; the cap of 2·`budget_i` is computed at BudgetWidth+1 bits.
- Admission: `consume_ready_o[ch]` = `enable_i[ch]` && left[ch, region] ≥ len + 1.
  - Compare at max(BudgetWidth, LenWidth+1) bits.
  - Ready does not depend on `consume_valid_i`.
  - If `consume_region_i` ≥ NumRegions, ready is 0.
- Accepted (valid && ready), with beats B = len + 1:
  - Non-replenish cycle: left ← left − B.
  - Replenish cycle: left ← sat0(R − B), where sat0 clamps below at 0.
- Not accepted: on a replenish cycle left ← R; otherwise left holds.
- `exhausted_o`:
  - Cleared on a replenish cycle whose resulting next left is nonzero.
  - Set whenever the next value of left is 0 while enabled.
- `stall_cnt_o[ch]`: increments each cycle with valid && !ready while enabled, saturating at all-ones. It is cleared only by disable or reset.
- `budget_i`/`period_i` changed while enabled: the new `budget_i` takes effect at the next replenish. The new `period_i` loads at the next period wrap. Running counters are not rewritten.

## Timing
- `consume_ready_o` is combinational from registered left and the current `consume_len_i`/`consume_region_i`. All other outputs are registered.
- A charge is visible on `budget_left_o` one cycle after the handshake cycle.
- Enable rising edge: accounting starts in that cycle from the values loaded while disabled.
- Enable falling edge: counters reload on the next edge; no pending charge survives.
- Reset asserted mid-operation: all state returns to reset values on the next `clk_i` edge, regardless of `enable_i`.
- Channels never interact. Simultaneous handshakes on all channels in one cycle are all charged.

## Configuration
- `AXI_RT_BUDGET_CARRY_EN` defined: carry-over mode is compiled in, behaving as described above.
- `AXI_RT_BUDGET_CARRY_EN` undefined:
  - `carry_i` is ignored and every channel uses reset-to-budget (R = `budget_i`).
  - The BudgetWidth+1 adder and the cap logic are not built.

## Test plan
- Reset, then enable ch0 with budget 8 and period 10; one handshake with len 3. Required: left 4 in the next cycle; left 8 again at replenish, exactly 10 cycles after enable.
- Budget 4, len 4 (5 beats) held valid for 6 cycles. Required: ready 0 throughout; `stall_cnt_o` = 6; `exhausted_o` stays 0.
- carry=1, budget 8, no traffic for 3 periods. Required: left goes 8→16 and holds at 16 (the 2× cap). Undefining `AXI_RT_BUDGET_CARRY_EN` with the same stimulus: left stays 8.
- Handshake with len 7 on a replenish cycle, budget 8, left 8, carry=0. Required: next left 0, `exhausted_o`=1; cleared to 0 with left 8 at the following replenish.
- Period 0, budget 2, len 0 issued every cycle. Required: ready 1 every cycle and left constantly 1.
- Disable mid-period, then assert reset mid-period on another channel. Required: the disabled channel reloads `budget_i`/`period_i` and has stall_cnt 0 after one cycle; the reset channel shows all outputs 0 after one cycle.
